// File: rtl/cl_pkg.sv
// cl_pkg: definitions shared by the word assembler and the metadata controller.
// Chart word layout: sys[31:29] | pitch[28:23] | string[22:20] | fret[19:16] | time[15:0].
// Also holds the default capacity and timeout values and the assembler state type.
package cl_pkg;

  localparam logic [2:0] END_TAG  = 3'b111;
  localparam logic [2:0] NOTE_TAG = 3'b000;

  localparam int SYS_MSB    = 31;
  localparam int SYS_LSB    = 29;
  localparam int PITCH_MSB  = 28;
  localparam int PITCH_LSB  = 23;
  localparam int STRING_MSB = 22;
  localparam int STRING_LSB = 20;
  localparam int FRET_MSB   = 19;
  localparam int FRET_LSB   = 16;
  localparam int TIME_MSB   = 15;
  localparam int TIME_LSB   = 0;

  localparam int MAX_WORDS    = 4096;
  localparam int TIMEOUT_CYC  = 250000;
  localparam int WORD_COUNT_W = 13;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DONE    = 2'd1,
    ST_ERROR   = 2'd2
  } asm_state_t;

endpackage

// File: rtl/cl_word_assembler_if.sv
// cl_word_assembler_if: byte-stream input and word-write output of the assembler,
// plus its status outputs.
//   byte_valid/byte_data       : one-cycle byte strobe from the serial receiver
//   write_en/write_word        : one-cycle write pulse toward the metadata controller
//   word_count, done, error,
//   timeout_count              : status
// master = byte source / status observer, slave = the assembler.
interface cl_word_assembler_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        write_en;
  logic [31:0] write_word;
  logic [12:0] word_count;
  logic        done;
  logic        error;
  logic [7:0]  timeout_count;

  modport master (
    output byte_valid, byte_data,
    input  write_en, write_word, word_count, done, error, timeout_count
  );

  modport slave (
    input  byte_valid, byte_data,
    output write_en, write_word, word_count, done, error, timeout_count
  );
endinterface

// File: rtl/cl_idle_timer.sv
// cl_idle_timer: idle-cycle counter with clear and enable.
//   clk, reset : clock and synchronous active-high reset
//   clear      : restart counting from zero (wins over everything else)
//   enable     : count this cycle
//   terminal   : combinational pulse in the cycle the count sits at TERMINAL-1 while enabled
// The counter wraps to zero on the terminal cycle so it is ready for the next partial word.
module cl_idle_timer #(
  parameter int TERMINAL = 250000,
  parameter int WIDTH    = $clog2(TERMINAL) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

  logic [WIDTH-1:0] count;

  assign terminal = enable && !clear && (count == LAST);

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear || terminal) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/cl_word_assembler.sv
// cl_word_assembler: packs received bytes (big-endian) into 32-bit chart words.
//   clk25, reset : 25 MHz clock, synchronous active-high reset
//   bus (slave)  : byte strobe in; registered write pulse, word and status out
// A word whose sys field equals END_TAG is written and ends the stream (done).
// A non-end word that would bring word_count to MAX_WORDS is dropped and raises error.
// A partial word idle for TIMEOUT_CYC cycles is discarded and counted.
module cl_word_assembler #(
  parameter int MAX_WORDS   = cl_pkg::MAX_WORDS,
  parameter int TIMEOUT_CYC = cl_pkg::TIMEOUT_CYC
) (
  input logic                 clk25,
  input logic                 reset,
  cl_word_assembler_if.slave  bus
);
  import cl_pkg::*;

  // Highest count at which a non-end word may still be written.
  localparam logic [WORD_COUNT_W-1:0] LAST_NOTE_COUNT = WORD_COUNT_W'(MAX_WORDS - 1);

  asm_state_t              state, state_next;
  logic [1:0]              byte_idx, byte_idx_next;
  logic [23:0]             shift, shift_next;
  logic                    write_en, write_en_next;
  logic [31:0]             write_word, write_word_next;
  logic [WORD_COUNT_W-1:0] word_count, word_count_next;
  logic                    done, done_next;
  logic                    error, error_next;
  logic [7:0]              timeout_count, timeout_count_next;
  logic [31:0]             completed;
  logic                    idle_expired;

  // A byte in the terminal cycle clears the timer, so the byte always wins.
  cl_idle_timer #(.TERMINAL(TIMEOUT_CYC)) u_idle_timer (
    .clk      (clk25),
    .reset    (reset),
    .clear    (bus.byte_valid),
    .enable   ((state == ST_COLLECT) && (byte_idx != 2'd0)),
    .terminal (idle_expired)
  );

  assign completed = {shift, bus.byte_data};

  // Next-state, shifter and counter logic.
  always_comb begin
    state_next         = state;
    byte_idx_next      = byte_idx;
    shift_next         = shift;
    write_en_next      = 1'b0;
    write_word_next    = write_word;
    word_count_next    = word_count;
    done_next          = done;
    error_next         = error;
    timeout_count_next = timeout_count;
    case (state)
      ST_COLLECT: begin
        if (bus.byte_valid) begin
          shift_next = completed[23:0];
          if (byte_idx == 2'd3) begin
            byte_idx_next = 2'd0;
            if (completed[SYS_MSB:SYS_LSB] == END_TAG) begin
              write_en_next   = 1'b1;
              write_word_next = completed;
              word_count_next = word_count + WORD_COUNT_W'(1);
              done_next       = 1'b1;
              state_next      = ST_DONE;
            end else if (word_count == LAST_NOTE_COUNT) begin
              error_next = 1'b1;
              state_next = ST_ERROR;
            end else begin
              write_en_next   = 1'b1;
              write_word_next = completed;
              word_count_next = word_count + WORD_COUNT_W'(1);
            end
          end else begin
            byte_idx_next = byte_idx + 2'd1;
          end
        end else if (idle_expired) begin
          byte_idx_next = 2'd0;
          if (timeout_count != 8'hFF) begin
            timeout_count_next = timeout_count + 8'd1;
          end else begin
            timeout_count_next = timeout_count;
          end
        end else begin
          byte_idx_next = byte_idx;
        end
      end
      ST_DONE: begin
        if (bus.byte_valid) begin
          error_next = 1'b1;
          state_next = ST_ERROR;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_ERROR: begin
        state_next = ST_ERROR;
      end
      default: begin
        error_next = 1'b1;
        state_next = ST_ERROR;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk25) begin
    if (reset) begin
      state         <= ST_COLLECT;
      byte_idx      <= 2'd0;
      shift         <= 24'd0;
      write_en      <= 1'b0;
      write_word    <= 32'd0;
      word_count    <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      timeout_count <= 8'd0;
    end else begin
      state         <= state_next;
      byte_idx      <= byte_idx_next;
      shift         <= shift_next;
      write_en      <= write_en_next;
      write_word    <= write_word_next;
      word_count    <= word_count_next;
      done          <= done_next;
      error         <= error_next;
      timeout_count <= timeout_count_next;
    end
  end

  assign bus.write_en      = write_en;
  assign bus.write_word    = write_word;
  assign bus.word_count    = word_count;
  assign bus.done          = done;
  assign bus.error         = error;
  assign bus.timeout_count = timeout_count;

endmodule

// File: tb/tb_cl_word_assembler.sv
// tb_cl_word_assembler: directed and randomized byte streams checked every cycle
// against a behavioural model of the assembler, plus literal expectations.
module tb_cl_word_assembler;

  localparam int MAXW = 8;
  localparam int TO   = 20;

  logic clk25 = 1'b0;
  logic reset = 1'b1;

  cl_word_assembler_if bus();

  cl_word_assembler #(.MAX_WORDS(MAXW), .TIMEOUT_CYC(TO)) dut (
    .clk25 (clk25),
    .reset (reset),
    .bus   (bus)
  );

  always #20 clk25 = ~clk25;

  int compares = 0;
  int fails    = 0;

  // Model state: pending bytes, last byte time, and the expected outputs.
  int          cyc     = 0;
  int          last_cyc = 0;
  int          nbytes  = 0;
  logic [31:0] acc     = 32'd0;
  logic        armed   = 1'b0;
  logic        m_we    = 1'b0;
  logic [31:0] m_word  = 32'd0;
  int          m_count = 0;
  logic        m_done  = 1'b0;
  logic        m_err   = 1'b0;
  int          m_tcnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: evaluated at every clock edge from the driven inputs.
  initial forever begin
    @(posedge clk25);
    cyc++;
    if (reset) begin
      armed = 1'b1; nbytes = 0; acc = 32'd0; m_we = 1'b0; m_word = 32'd0;
      m_count = 0; m_done = 1'b0; m_err = 1'b0; m_tcnt = 0;
    end else begin
      m_we = 1'b0;
      if (m_err) begin
        m_err = 1'b1;
      end else if (m_done) begin
        if (bus.byte_valid) m_err = 1'b1;
      end else if (bus.byte_valid) begin
        acc = {acc[23:0], bus.byte_data};
        nbytes++;
        last_cyc = cyc;
        if (nbytes == 4) begin
          nbytes = 0;
          if (acc[31:29] == 3'b111) begin
            m_we = 1'b1; m_word = acc; m_count++; m_done = 1'b1;
          end else if (m_count + 1 == MAXW) begin
            m_err = 1'b1;
          end else begin
            m_we = 1'b1; m_word = acc; m_count++;
          end
        end
      end else if (nbytes != 0 && cyc - last_cyc == TO) begin
        nbytes = 0;
        if (m_tcnt < 255) m_tcnt++;
      end
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model.
  initial forever begin
    @(negedge clk25);
    if (armed) begin
      check("write_en", {31'd0, bus.write_en}, {31'd0, m_we});
      check("write_word", bus.write_word, m_word);
      check("word_count", {19'd0, bus.word_count}, 32'(m_count));
      check("done", {31'd0, bus.done}, {31'd0, m_done});
      check("error", {31'd0, bus.error}, {31'd0, m_err});
      check("timeout_count", {24'd0, bus.timeout_count}, 32'(m_tcnt));
    end
  end

  task automatic put(input logic v, input logic [7:0] d);
    bus.byte_valid = v;
    bus.byte_data  = d;
    @(negedge clk25);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    @(negedge clk25);
    reset = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] w);
    put(1'b1, w[31:24]); put(1'b1, w[23:16]); put(1'b1, w[15:8]); put(1'b1, w[7:0]);
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    @(negedge clk25);
    do_reset();
    check("rst_write_en", {31'd0, bus.write_en}, 32'd0);
    check("rst_word_count", {19'd0, bus.word_count}, 32'd0);
    check("rst_write_word", bus.write_word, 32'd0);

    // Single word, back-to-back bytes.
    put(1'b1, 8'h12); put(1'b1, 8'h34); put(1'b1, 8'h56);
    check("pre_pulse", {31'd0, bus.write_en}, 32'd0);
    put(1'b1, 8'h78);
    check("w1_pulse", {31'd0, bus.write_en}, 32'd1);
    check("w1_word", bus.write_word, 32'h12345678);
    check("w1_count", {19'd0, bus.word_count}, 32'd1);
    idle(1);
    check("w1_single", {31'd0, bus.write_en}, 32'd0);

    // Three notes then an end word, then a stray byte.
    do_reset();
    put_word(32'h01020304); put_word(32'h05060708); put_word(32'h090A0B0C);
    put_word(32'hE0000000);
    check("end_word", bus.write_word, 32'hE0000000);
    check("end_count", {19'd0, bus.word_count}, 32'd4);
    check("end_done", {31'd0, bus.done}, 32'd1);
    put(1'b1, 8'h55);
    check("after_done_err", {31'd0, bus.error}, 32'd1);
    check("after_done_we", {31'd0, bus.write_en}, 32'd0);
    idle(2);

    // Timeout discards a partial word.
    do_reset();
    put(1'b1, 8'hAA); put(1'b1, 8'hBB);
    idle(TO);
    check("to_count", {24'd0, bus.timeout_count}, 32'd1);
    put_word(32'h01020304);
    check("to_word", bus.write_word, 32'h01020304);
    check("to_wcount", {19'd0, bus.word_count}, 32'd1);

    // Byte in the terminal cycle wins over the timeout.
    do_reset();
    put(1'b1, 8'hAA); put(1'b1, 8'hBB);
    idle(TO - 1);
    put(1'b1, 8'hCC); put(1'b1, 8'hDD);
    check("edge_word", bus.write_word, 32'hAABBCCDD);
    check("edge_tcount", {24'd0, bus.timeout_count}, 32'd0);

    // Overflow at MAX_WORDS.
    do_reset();
    for (int i = 0; i < MAXW; i++) put_word({8'h0A, 8'(i), 16'h1234});
    check("ovf_err", {31'd0, bus.error}, 32'd1);
    check("ovf_count", {19'd0, bus.word_count}, 32'd7);
    check("ovf_we", {31'd0, bus.write_en}, 32'd0);
    put_word(32'h01020304);
    check("ovf_ignore", {19'd0, bus.word_count}, 32'd7);

    // Reset mid-word.
    do_reset();
    put(1'b1, 8'hDE); put(1'b1, 8'hAD);
    do_reset();
    put_word(32'h11223344);
    check("mid_rst_word", bus.write_word, 32'h11223344);
    check("mid_rst_count", {19'd0, bus.word_count}, 32'd1);

    // Randomized streams.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 1) do_reset();
      else if (r < 60) put(1'b1, 8'($urandom));
      else if (r < 92) put(1'b0, 8'h00);
      else idle(int'($urandom_range(TO - 3, TO + 3)));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

  // Hard time limit.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
